// File: rtl/mid_buffer_pkg.sv
// Shared types and default geometry for the mid-buffer address controller.
package mid_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned DEF_ROWS   = 34;
    localparam int unsigned DEF_COLS   = 26;
    localparam int unsigned DEF_WIN    = 2;
    localparam int unsigned DEF_STRIDE = 2;

endpackage

// File: rtl/midbuf_wrap_cnt.sv
// Wrapping up-counter: clears on clr, steps by STEP on en, wraps to zero at TERM.
module midbuf_wrap_cnt #(
    parameter int unsigned W    = 6,
    parameter int unsigned TERM = 33,
    parameter int unsigned STEP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         carry_c
);

    logic at_term;

    assign at_term = (count == W'(TERM));
    assign carry_c = en && at_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_term ? '0 : count + W'(STEP);
        end
    end

endmodule

// File: rtl/mid_buffer_ctrl.sv
// Mid-buffer controller: fills a ROWS x COLS buffer, then scans STRIDE-stepped windows.
// Optional sticky overrun flag is built when MIDBUF_OVERRUN_DET_EN is defined.
module mid_buffer_ctrl
    import mid_buffer_pkg::*;
#(
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned WIN    = DEF_WIN,
    parameter int unsigned STRIDE = DEF_STRIDE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic                    win_ready,
    output logic                    wr_en,
    output logic [$clog2(ROWS)-1:0] wr_row,
    output logic [$clog2(COLS)-1:0] wr_col,
    output logic                    win_valid,
    output logic [$clog2(ROWS)-1:0] win_row,
    output logic [$clog2(COLS)-1:0] win_col,
    output logic                    win_last,
    output logic [1:0]              state,
    output logic                    frame_done
`ifdef MIDBUF_OVERRUN_DET_EN
    ,
    output logic                    overrun
`endif
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);

    state_t state_q, state_d;
    logic   wr_clr_c, win_clr_c;
    logic   wr_col_wrap_c, last_wr_c;
    logic   hs_c, win_col_wrap_c, last_hs_c;

    assign hs_c = win_valid && win_ready;

    // Write address: column steps per write, row steps on column wrap.
    midbuf_wrap_cnt #(.W(CW), .TERM(COLS - 1), .STEP(1)) u_wr_col (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wr_clr_c),
        .en      (wr_en),
        .count   (wr_col),
        .carry_c (wr_col_wrap_c)
    );

    midbuf_wrap_cnt #(.W(RW), .TERM(ROWS - 1), .STEP(1)) u_wr_row (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wr_clr_c),
        .en      (wr_col_wrap_c),
        .count   (wr_row),
        .carry_c (last_wr_c)
    );

    // Window origin: column steps per handshake, row steps on column wrap.
    midbuf_wrap_cnt #(.W(CW), .TERM(COLS - WIN), .STEP(STRIDE)) u_win_col (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (win_clr_c),
        .en      (hs_c),
        .count   (win_col),
        .carry_c (win_col_wrap_c)
    );

    midbuf_wrap_cnt #(.W(RW), .TERM(ROWS - WIN), .STEP(STRIDE)) u_win_row (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (win_clr_c),
        .en      (win_col_wrap_c),
        .count   (win_row),
        .carry_c (last_hs_c)
    );

    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        wr_clr_c  = 1'b0;
        win_clr_c = 1'b1;
        case (state_q)
            ST_IDLE: begin
                wr_en = valid_in;
                if (valid_in) state_d = ST_FILL;
            end
            ST_FILL: begin
                wr_en = valid_in;
                if (last_wr_c) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                wr_clr_c  = 1'b1;
                win_clr_c = 1'b0;
                if (last_hs_c) state_d = ST_DONE;
            end
            ST_DONE: begin
                wr_clr_c = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_valid  <= (state_d == ST_SCAN);
            frame_done <= (state_d == ST_DONE);
        end
    end

    assign state    = state_q;
    assign win_last = win_valid && (win_row == RW'(ROWS - WIN)) && (win_col == CW'(COLS - WIN));

`ifdef MIDBUF_OVERRUN_DET_EN
    // Pixels arriving while the buffer is being read are lost; remember that it happened.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (valid_in && (state_q == ST_SCAN || state_q == ST_DONE)) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mid_buffer_ctrl.sv
// Self-checking bench for mid_buffer_ctrl against a linear-index frame model.
// Overrun checks are compiled in when MIDBUF_OVERRUN_DET_EN is defined.
module tb_mid_buffer_ctrl;

    localparam int ROWS   = 34;
    localparam int COLS   = 26;
    localparam int WIN    = 2;
    localparam int STRIDE = 2;
    localparam int NWX    = (COLS - WIN) / STRIDE + 1;
    localparam int NWY    = (ROWS - WIN) / STRIDE + 1;
    localparam int NWIN   = NWX * NWY;
    localparam int NPIX   = ROWS * COLS;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_in;
    logic       win_ready;
    logic       wr_en;
    logic [5:0] wr_row;
    logic [4:0] wr_col;
    logic       win_valid;
    logic [5:0] win_row;
    logic [4:0] win_col;
    logic       win_last;
    logic [1:0] state;
    logic       frame_done;
`ifdef MIDBUF_OVERRUN_DET_EN
    logic       overrun;
`endif

    int total = 0;
    int bad   = 0;

    // Model: phase 0..3, k = pixels written so far, w = windows consumed so far.
    int m_phase, m_k, m_w;
    bit m_ovr;

    typedef struct {
        logic v;
        logic r;
        int   st;
        int   we;
        int   row;
        int   col;
        int   wv;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    mid_buffer_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .win_ready  (win_ready),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .win_last   (win_last),
        .state      (state),
        .frame_done (frame_done)
`ifdef MIDBUF_OVERRUN_DET_EN
        ,
        .overrun    (overrun)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_k     = 0;
        m_w     = 0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_update(input logic v, input logic r);
        case (m_phase)
            0: if (v) begin
                m_k     = 1;
                m_phase = 1;
            end
            1: if (v) begin
                if (m_k == NPIX - 1) begin
                    m_k     = 0;
                    m_phase = 2;
                end else begin
                    m_k++;
                end
            end
            2: begin
                if (v) m_ovr = 1'b1;
                if (r) begin
                    if (m_w == NWIN - 1) begin
                        m_w     = 0;
                        m_phase = 3;
                    end else begin
                        m_w++;
                    end
                end
            end
            default: begin
                if (v) m_ovr = 1'b1;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic check_model();
        chk("state", int'(state), m_phase);
        chk("wr_en", int'(wr_en), int'(valid_in && m_phase < 2));
        chk("wr_row", int'(wr_row), m_k / COLS);
        chk("wr_col", int'(wr_col), m_k % COLS);
        chk("win_valid", int'(win_valid), int'(m_phase == 2));
        chk("win_row", int'(win_row), (m_w / NWX) * STRIDE);
        chk("win_col", int'(win_col), (m_w % NWX) * STRIDE);
        chk("win_last", int'(win_last), int'(m_phase == 2 && m_w == NWIN - 1));
        chk("frame_done", int'(frame_done), int'(m_phase == 3));
`ifdef MIDBUF_OVERRUN_DET_EN
        chk("overrun", int'(overrun), int'(m_ovr));
`endif
    endtask

    // One cycle: drive at negedge, check before the rising edge, advance model.
    task automatic step(input logic v, input logic r,
                        output logic o_we, output logic o_fd,
                        output logic o_last_hs, output logic o_busy);
        valid_in  = v;
        win_ready = r;
        #1;
        check_model();
        o_we      = wr_en;
        o_fd      = frame_done;
        o_last_hs = win_last && win_valid && r;
        o_busy    = (state != 2'd0);
        @(posedge clk);
        model_update(v, r);
        @(negedge clk);
    endtask

    task automatic check_in_reset(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_wr_row"}, int'(wr_row), 0);
        chk({tag, "_wr_col"}, int'(wr_col), 0);
        chk({tag, "_win_valid"}, int'(win_valid), 0);
        chk({tag, "_win_row"}, int'(win_row), 0);
        chk({tag, "_win_col"}, int'(win_col), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
`ifdef MIDBUF_OVERRUN_DET_EN
        chk({tag, "_overrun"}, int'(overrun), 0);
`endif
    endtask

    // mode 0: all ones; mode 1: valid gap every 5th, ready 1-of-3; mode 2: random.
    task automatic run_frame(input int mode);
        int   n, writes, dones, lasts, busy;
        bit   started;
        logic v, r, we, fd, lh, bz;
        n = 0; writes = 0; dones = 0; lasts = 0; busy = 0; started = 1'b0;
        while (n < 6000) begin
            case (mode)
                0: begin v = 1'b1; r = 1'b1; end
                1: begin v = ((n % 5) != 4); r = ((n % 3) == 0); end
                default: begin v = ($urandom_range(0, 3) != 0); r = 1'($urandom_range(0, 1)); end
            endcase
            step(v, r, we, fd, lh, bz);
            n++;
            writes += int'(we);
            dones  += int'(fd);
            lasts  += int'(lh);
            busy   += int'(bz);
            if (m_phase != 0) started = 1'b1;
            if (started && m_phase == 0) break;
        end
        chk("frame_timeout", int'(n >= 6000), 0);
        chk("frame_writes", writes, NPIX);
        chk("frame_done_pulses", dones, 1);
        chk("win_last_handshakes", lasts, 1);
        if (mode == 0) chk("frame_busy_cycles", busy, NPIX + NWIN);
    endtask

    initial begin
        logic we, fd, lh, bz;
        int   n;

        tbl[0] = '{v: 1'b0, r: 1'b0, st: 0, we: 0, row: 0, col: 0, wv: 0};
        tbl[1] = '{v: 1'b1, r: 1'b0, st: 0, we: 1, row: 0, col: 0, wv: 0};
        tbl[2] = '{v: 1'b1, r: 1'b1, st: 1, we: 1, row: 0, col: 1, wv: 0};
        tbl[3] = '{v: 1'b0, r: 1'b0, st: 1, we: 0, row: 0, col: 2, wv: 0};
        tbl[4] = '{v: 1'b1, r: 1'b0, st: 1, we: 1, row: 0, col: 2, wv: 0};
        tbl[5] = '{v: 1'b1, r: 1'b1, st: 1, we: 1, row: 0, col: 3, wv: 0};

        valid_in  = 1'b0;
        win_ready = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        #2;
        check_in_reset("rst");
        chk("rst_wr_en", int'(wr_en), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            valid_in  = tbl[i].v;
            win_ready = tbl[i].r;
            #1;
            chk("tbl_state", int'(state), tbl[i].st);
            chk("tbl_wr_en", int'(wr_en), tbl[i].we);
            chk("tbl_wr_row", int'(wr_row), tbl[i].row);
            chk("tbl_wr_col", int'(wr_col), tbl[i].col);
            chk("tbl_win_valid", int'(win_valid), tbl[i].wv);
            @(negedge clk);
        end

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        run_frame(0);
        run_frame(1);
        run_frame(2);

        // Async reset in the middle of the scan, at window 100.
        n = 0;
        while (n < 3000 && !(m_phase == 2 && m_w == 100)) begin
            step(1'b1, 1'b1, we, fd, lh, bz);
            n++;
        end
        chk("reach_win100_timeout", int'(n >= 3000), 0);
        chk("win100_row", int'(win_row), (100 / NWX) * STRIDE);
        chk("win100_col", int'(win_col), (100 % NWX) * STRIDE);
        #2;
        rst_n = 1'b0;
        #1;
        check_in_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_frame(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mid_buffer_ctrl.md
MID_BUFFER_CTRL -- requirements
Module: mid_buffer_ctrl

Interface
REQ-001 Parameter ROWS, 34, padded feature-map rows held by the mid buffer.
REQ-002 Parameter COLS, 26, padded feature-map columns.
REQ-003 Parameter WIN, 2, square window edge length.
REQ-004 Parameter STRIDE, 2, window step in rows and columns.
REQ-005 Port clk  input  1  single clock; all state changes on rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 Port valid_in  input  1  32-channel pixel vector present this cycle.
REQ-008 Port win_ready  input  1  downstream accepts the current window.
REQ-009 Port wr_en  output  1  buffer write strobe.
REQ-010 Port wr_row  output  $clog2(ROWS)  write row address.
REQ-011 Port wr_col  output  $clog2(COLS)  write column address.
REQ-012 Port win_valid  output  1  window address valid.
REQ-013 Port win_row / win_col  output  $clog2(ROWS) / $clog2(COLS)  top-left of the current window.
REQ-014 Port win_last  output  1  current window is the final one of the frame.
REQ-015 Port state  output  2  FSM state encoding.
REQ-016 Port frame_done  output  1  one-cycle pulse at frame end.
REQ-017 Port overrun  output  1  sticky error flag; present only with MIDBUF_OVERRUN_DET_EN.

Function
REQ-018 FSM states: IDLE=0, FILL=1, SCAN=2, DONE=3.
REQ-019 wr_en SHALL equal valid_in when state is IDLE or FILL, and 0 otherwise (combinational).
REQ-020 wr_en writes go to (wr_row, wr_col). On each write, wr_col increments. At COLS-1, wr_col wraps to 0 and wr_row increments.
REQ-021 IDLE with valid_in=1: write at (0,0) and go to FILL next cycle.
REQ-022 FILL with a write at (ROWS-1, COLS-1): go to SCAN next cycle and clear wr_row/wr_col. Idle cycles (valid_in=0) hold the addresses.
REQ-023 SCAN: win_valid=1 and is registered. win_row/win_col start at (0,0) and hold while win_ready=0.
REQ-024 Handshake (win_valid && win_ready): win_col advances by STRIDE. At column COLS-WIN, win_col wraps to 0 and win_row advances by STRIDE.
REQ-025 win_last=1 when win_row=ROWS-WIN and win_col=COLS-WIN. Defaults give 17x13=221 windows.
REQ-026 Handshake with win_last=1: go to DONE and clear the window counters.
REQ-027 DONE lasts one cycle with frame_done=1, then returns to IDLE. valid_in during DONE is not written.
REQ-028 valid_in during SCAN or DONE SHALL be dropped (wr_en=0).
REQ-029 Minimum frame time: ROWS*COLS + (windows) + 1 cycles = 1106 with defaults.
REQ-030 All arithmetic is unsigned. Counters never exceed their terminal values.

Reset
REQ-031 rst_n=0 SHALL immediately force: state=IDLE, all address counters 0, win_valid=0, frame_done=0, overrun=0.
REQ-032 Reset mid-FILL or mid-SCAN abandons the frame. The first valid_in after release writes (0,0).

Configuration
REQ-033 MIDBUF_OVERRUN_DET_EN defined: overrun is set on any valid_in=1 during SCAN or DONE, and stays set until reset.
REQ-034 MIDBUF_OVERRUN_DET_EN undefined: the overrun port and logic are absent; dropping behaviour is unchanged.

Structure
REQ-035 Package mid_buffer_pkg SHALL hold the state enum and the default ROWS/COLS/WIN/STRIDE constants.
REQ-036 Sub-module midbuf_wrap_cnt (load-zero, enable, step, terminal-value wrap, carry out) SHALL be instantiated for the write and window row/column counters.

Verification
REQ-037 884 consecutive valid_in after reset -> wr_en=1 for 884 cycles, last write at (33,25), state=SCAN on cycle 885.
REQ-038 win_ready held 1 -> 221 windows in 221 cycles: sequence (0,0),(0,2)..(0,24),(2,0)..(32,24); win_last only on (32,24); frame_done pulses once; then IDLE.
REQ-039 win_ready toggled 1-of-3 cycles -> same 221-window sequence, win_row/win_col stable while stalled.
REQ-040 Gaps in valid_in during FILL (e.g. 0 every 5th cycle) -> addresses hold, still exactly 884 writes before SCAN.
REQ-041 valid_in=1 during SCAN -> wr_en=0 and no address change; with the macro, overrun=1 sticky until rst_n=0.
REQ-042 rst_n pulsed at window 100 -> state=IDLE, win_valid=0 asynchronously; the next frame restarts at (0,0).
